// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the UART transmit arbiter: level requests with their bytes,
// and the one-cycle grant/ack pulses returned to each source.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   ack;

   modport master (output req, output req_data, input grant, input ack);
   modport slave  (input req, input req_data, output grant, output ack);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one 8N1 UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to abort a frame whose transmitter never reports busy.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_arbiter_if.slave req_if,
   output logic [7:0]       tx_data_o,
   output logic             tx_send_o,
   input  logic             tx_busy_i,
   output logic             busy_o,
   output logic             err_o
);
   localparam int PW = $clog2(NUM_REQ);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;

   localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
   localparam logic [2:0] S_AFTER  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be 2..8");
   end
   if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("uart_tx_arbiter: GAP_CYCLES must be 0..255");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT_CYCLES must be 1..256");
   end

   logic [2:0]         state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_send_q, tx_send_d;
   logic               busy_q;
   logic [7:0]         gap_cnt_q, gap_cnt_d;
   logic [PW-1:0]      winner;
   logic               win_found;
   logic [NUM_REQ-1:0] ptr_onehot;
`ifdef UART_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] to_cnt_q, to_cnt_d;
   logic       err_q, err_d;
`endif

   function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PW'(s);
   endfunction

   // First requester after the pointer wins, so the last winner drops to lowest priority.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      winner    = ptr_q;
      win_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!win_found && req_if.req[rr_idx(ptr_q, k)]) begin
            win_found = 1'b1;
            winner    = rr_idx(ptr_q, k);
         end
      end
   end

   assign ptr_onehot = NUM_REQ'(1) << ptr_q;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = '0;
      ack_d     = '0;
      tx_data_d = tx_data_q;
      tx_send_d = tx_send_q;
      gap_cnt_d = gap_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
      err_d     = err_q;
`endif
      case (state_q)
         S_IDLE: if (|req_if.req && !tx_busy_i) state_d = S_LOAD;
         S_LOAD: begin
            if (win_found) begin
               tx_data_d       = req_if.req_data[8*winner +: 8];
               grant_d[winner] = 1'b1;
               ptr_d           = winner;
               tx_send_d       = 1'b1;
               state_d         = S_START;
`ifdef UART_ARB_TIMEOUT_EN
               to_cnt_d        = 8'd0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (tx_busy_i) begin
               tx_send_d = 1'b0;
               state_d   = S_SEND;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (to_cnt_q >= TO_LAST) begin
               // Transmitter never started: drop the byte but still release the requester.
               tx_send_d = 1'b0;
               err_d     = 1'b1;
               ack_d     = ptr_onehot;
               gap_cnt_d = 8'd0;
               state_d   = S_AFTER;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
`endif
         end
         S_SEND: begin
            if (!tx_busy_i) begin
               ack_d   = ptr_onehot;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            gap_cnt_d = 8'd0;
            state_d   = S_AFTER;
         end
         S_GAP: begin
            if (gap_cnt_q >= GAP_LAST) state_d = S_IDLE;
            else                       gap_cnt_d = gap_cnt_q + 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= PW'(NUM_REQ - 1);
         grant_q   <= '0;
         ack_q     <= '0;
         tx_data_q <= 8'h00;
         tx_send_q <= 1'b0;
         busy_q    <= 1'b0;
         gap_cnt_q <= 8'd0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         tx_data_q <= tx_data_d;
         tx_send_q <= tx_send_d;
         busy_q    <= (state_d != S_IDLE);
         gap_cnt_q <= gap_cnt_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= 8'd0;
         err_q    <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         err_q    <= err_d;
      end
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign req_if.grant = grant_q;
   assign req_if.ack   = ack_q;
   assign tx_data_o    = tx_data_q;
   assign tx_send_o    = tx_send_q;
   assign busy_o       = busy_q;
endmodule
